// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (data over fetch, with fetch anti-starvation) in front of the SRAM controller.
// Define MEM_ARB_RDATA_REG_EN to register read data and read acks (read latency 2).
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
    parameter int unsigned ADDR_BITS    = `MEM_ADDR_BITS,
    parameter int unsigned DATA_BITS    = `XLEN,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_reset,
    input  logic                   if_req,
    input  logic [ADDR_BITS-1:0]   if_addr,
    output logic                   if_gnt,
    output logic                   if_ack,
    output logic [DATA_BITS-1:0]   if_rdata,
    input  logic                   d_re,
    input  logic [DATA_BITS/8-1:0] d_we,
    input  logic [ADDR_BITS-1:0]   d_addr,
    input  logic [DATA_BITS-1:0]   d_wdata,
    output logic                   d_gnt,
    output logic                   d_ack,
    output logic [DATA_BITS-1:0]   d_rdata,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_BITS/8-1:0] mem_write_en,
    output logic [DATA_BITS-1:0]   mem_write_data,
    output logic                   mem_read_en,
    input  logic                   mem_read_ack,
    input  logic [DATA_BITS-1:0]   mem_read_data
);

    typedef enum logic [1:0] {IDLE, IF_RD, D_RD, D_WR} owner_t;

    owner_t                 owner_d1;
    owner_t                 owner_nxt;
    logic [3:0]             starve_cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   err_stray;
    logic                   active;
    logic                   d_wr;
    logic                   d_req;
    logic                   force_if;
    logic                   stray_ack;

    always_comb begin
        active    = reset_n & ~sync_reset;
        d_wr      = |d_we;
        d_req     = d_re | d_wr;
        force_if  = (starve_cnt == 4'(STARVE_LIMIT)) & if_req;
        stray_ack = mem_read_ack & ((owner_d1 == IDLE) | (owner_d1 == D_WR));
        owner_nxt = IDLE;
        if (active) begin
            if (force_if)
                owner_nxt = IF_RD;
            else if (d_req)
                owner_nxt = d_wr ? D_WR : D_RD;
            else if (if_req)
                owner_nxt = IF_RD;
        end
    end

    always_comb begin
        if_gnt         = 1'b0;
        d_gnt          = 1'b0;
        mem_read_en    = 1'b0;
        mem_write_en   = '0;
        mem_write_data = '0;
        mem_addr       = addr_q;
        case (owner_nxt)
            IF_RD: begin
                if_gnt      = 1'b1;
                mem_read_en = 1'b1;
                mem_addr    = if_addr;
            end
            D_RD: begin
                d_gnt       = 1'b1;
                mem_read_en = 1'b1;
                mem_addr    = d_addr;
            end
            D_WR: begin
                d_gnt          = 1'b1;
                mem_write_en   = d_we;
                mem_write_data = d_wdata;
                mem_addr       = d_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_d1   <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            err_stray  <= 1'b0;
        end else if (sync_reset) begin
            owner_d1   <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            err_stray  <= 1'b0;
        end else begin
            owner_d1  <= owner_nxt;
            err_stray <= err_stray | stray_ack;
            if (owner_nxt != IDLE)
                addr_q <= mem_addr;
            if (!if_req || owner_nxt == IF_RD)
                starve_cnt <= '0;
            else if (starve_cnt != 4'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef MEM_ARB_RDATA_REG_EN
    owner_t               owner_d2;
    logic                 ack_d2;
    logic [DATA_BITS-1:0] rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_d2 <= IDLE;
            ack_d2   <= 1'b0;
            rdata_q  <= '0;
        end else if (sync_reset) begin
            owner_d2 <= IDLE;
            ack_d2   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            owner_d2 <= owner_d1;
            ack_d2   <= mem_read_ack;
            if (mem_read_ack)
                rdata_q <= mem_read_data;
        end
    end

    // Read acks come from the second stage; write acks stay on the first.
    always_comb begin
        if_ack   = active & ack_d2 & (owner_d2 == IF_RD);
        d_ack    = active & ((ack_d2 & (owner_d2 == D_RD)) | (owner_d1 == D_WR));
        if_rdata = rdata_q;
        d_rdata  = rdata_q;
    end
`else
    always_comb begin
        if_ack   = active & mem_read_ack & (owner_d1 == IF_RD);
        d_ack    = active & ((mem_read_ack & (owner_d1 == D_RD)) | (owner_d1 == D_WR));
        if_rdata = mem_read_data;
        d_rdata  = mem_read_data;
    end
`endif

endmodule
